// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - in-line scoreboard checker for the 4-bit ALU interface
//
// Purpose:
//   Samples every valid ALU input transaction and computes its expected result
//   with a golden model. Expected results are queued in order. The head entry is
//   compared against the DUT result on each valid_out. The block keeps saturating
//   packet/pass/fail counters, a timeout watchdog and sticky error flags.
//
// Optional feature (macro ALU_CHK_STOP_ON_FAIL_EN):
//   defined   - the first mismatch stops the checker (FIFO and counters freeze,
//               halted rises the cycle after the mismatch pulse)
//   undefined - mismatches only count and pulse; halted rises only on timeout
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   valid_in   in   DUT input transaction valid
//   a, b       in   DUT operands (4 bit)
//   cin        in   DUT carry input
//   ctl        in   DUT opcode (4 bit)
//   valid_out  in   DUT result valid
//   alu        in   DUT result (4 bit)
//   carry      in   DUT carry output
//   zero       in   DUT zero output
//   pkt_num    out  checked (popped) transaction count, saturating
//   pass_cnt   out  matching result count, saturating
//   fail_cnt   out  mismatching result count, saturating
//   mismatch   out  one-cycle pulse per failed compare
//   pending    out  expected-result FIFO occupancy
//   err_ovf    out  sticky: push while full without a pop
//   err_unf    out  sticky: valid_out while the FIFO is empty
//   err_tmo    out  sticky: watchdog expired
//   halted     out  checker stopped

module alu_result_checker #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [3:0]                 a,
  input  logic [3:0]                 b,
  input  logic                       cin,
  input  logic [3:0]                 ctl,
  input  logic                       valid_out,
  input  logic [3:0]                 alu,
  input  logic                       carry,
  input  logic                       zero,
  output logic [CNT_W-1:0]           pkt_num,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt,
  output logic                       mismatch,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic                       err_tmo,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_STOP   = 2'd2
  } state_t;

  // Golden model: returns {carry, zero, result}. Arithmetic runs in 5 bits so
  // bit 4 is the carry (add) or borrow (subtract).
  function automatic logic [5:0] golden(input logic [3:0] ga, input logic [3:0] gb,
                                        input logic gc, input logic [3:0] op);
    logic [4:0] x;
    x = 5'd0;
    case (op)
      4'd0:  x = {1'b0, ga} + {1'b0, gb};
      4'd1:  x = {1'b0, ga} + {1'b0, gb} + {4'd0, gc};
      4'd2:  x = {1'b0, ga} - {1'b0, gb};
      4'd3:  x = {1'b0, ga} - {1'b0, gb} - {4'd0, gc};
      4'd4:  x = {1'b0, ga & gb};
      4'd5:  x = {1'b0, ga | gb};
      4'd6:  x = {1'b0, ga ^ gb};
      4'd7:  x = {1'b0, ~ga};
      4'd8:  x = {ga[3], ga[2:0], 1'b0};
      4'd9:  x = {ga[0], 1'b0, ga[3:1]};
      4'd10: x = {1'b0, ga} + 5'd1;
      4'd11: x = {1'b0, ga} - 5'd1;
      4'd12: x = {1'b0, ga};
      4'd13: x = {1'b0, gb};
      4'd14: x = 5'd0;
      4'd15: x = {1'b0, ~(ga & gb)};
      default: x = 5'd0;
    endcase
    return {x[4], (x[3:0] == 4'd0), x[3:0]};
  endfunction

  state_t            state_q;
  logic [5:0]        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [PW-1:0]     count_q;
  logic [PW-1:0]     count_d;
  logic [WW-1:0]     wd_q;
  logic [CNT_W-1:0]  pkt_q;
  logic [CNT_W-1:0]  pass_q;
  logic [CNT_W-1:0]  fail_q;
  logic              mismatch_q;
  logic              err_ovf_q;
  logic              err_unf_q;
  logic              err_tmo_q;
  logic              halted_q;

  logic              stopped;
  logic              empty;
  logic              full;
  logic              push_req;
  logic              do_push;
  logic              do_pop;
  logic              ovf_now;
  logic              unf_now;
  logic              fail_now;
  logic              fail_stop;
  logic              tmo_hit;
  logic [5:0]        exp_entry;

  always_comb begin
    stopped   = (state_q == S_STOP);
    empty     = (count_q == '0);
    full      = (count_q == PW'(DEPTH));
    // The DUT has at least one cycle of latency, so a pop only ever sees
    // entries pushed on earlier edges; an empty FIFO is an underflow even if
    // valid_in is high on the same edge.
    do_pop    = valid_out && !empty && !stopped;
    push_req  = valid_in && !stopped;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    do_push   = push_req && (!full || do_pop);
    ovf_now   = push_req && full && !do_pop;
    unf_now   = valid_out && empty && !stopped;
    exp_entry = mem_q[rd_ptr_q];
    fail_now  = do_pop && (exp_entry != {carry, zero, alu});
    tmo_hit   = !stopped && !do_pop && !empty && (wd_q == WW'(TIMEOUT - 1));

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef ALU_CHK_STOP_ON_FAIL_EN
  assign fail_stop = fail_now;
`else
  assign fail_stop = 1'b0;
`endif

  // Entry storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= golden(a, b, cin, ctl);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wd_q       <= '0;
      pkt_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      mismatch_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      mismatch_q <= fail_now;
      count_q    <= count_d;

      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end

      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        if (pkt_q != '1) pkt_q <= pkt_q + CNT_W'(1);
        if (fail_now) begin
          if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
        end else begin
          if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
        end
      end

      if (ovf_now) err_ovf_q <= 1'b1;
      if (unf_now) err_unf_q <= 1'b1;

      // Watchdog freezes once stopped so it cannot re-trigger or wrap.
      if (!stopped) begin
        if (do_pop || empty) wd_q <= '0;
        else                 wd_q <= wd_q + WW'(1);
      end
      if (tmo_hit) err_tmo_q <= 1'b1;

      // halted follows the STOP state one cycle late, except that a timeout
      // raises it together with err_tmo.
      halted_q <= stopped || tmo_hit;

      case (state_q)
        S_IDLE: begin
          if (do_push) state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (tmo_hit || fail_stop) state_q <= S_STOP;
          else if (count_d == '0)   state_q <= S_IDLE;
        end
        S_STOP: begin
          state_q <= S_STOP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pkt_num  = pkt_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign mismatch = mismatch_q;
  assign pending  = count_q;
  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;
  assign err_tmo  = err_tmo_q;
  assign halted   = halted_q;

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Synthesizable in-line checker sitting on the ALU interface alongside the 4-bit ALU DUT.
- Samples each valid input transaction and computes the expected result with a golden model.
- Queues expected results in order, pops one per DUT valid_out, and compares alu/carry/zero.
- Keeps pass/fail/packet counters, a timeout watchdog and sticky error flags for bench and emulation use.

Parameters:
- DEPTH, 8: expected-result FIFO entries (power of 2, >=2)
- TIMEOUT, 64: max cycles with FIFO non-empty and no valid_out before timeout error
- CNT_W, 16: width of packet/pass/fail counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- valid_in  in  1  DUT input transaction valid
- a  in  4  DUT port A
- b  in  4  DUT port B
- cin  in  1  DUT carry input
- ctl  in  4  DUT opcode
- valid_out  in  1  DUT result valid
- alu  in  4  DUT result
- carry  in  1  DUT carry output
- zero  in  1  DUT zero output
- pkt_num  out  CNT_W  count of checked (popped) transactions
- pass_cnt  out  CNT_W  matching results
- fail_cnt  out  CNT_W  mismatching results
- mismatch  out  1  one-cycle pulse per failed compare
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- err_ovf  out  1  sticky: push while full without pop
- err_unf  out  1  sticky: valid_out while FIFO empty
- err_tmo  out  1  sticky: watchdog expired
- halted  out  1  checker stopped (see Optional Feature)

Behaviour:
- Golden model: 5-bit {c,r}, 4-bit inputs zero-extended. ctl:
  - 0 ADD a+b; 1 ADDC a+b+cin; 2 SUB a-b; 3 SUBB a-b-cin (c = borrow, bit 4 of 5-bit difference)
  - 4 AND; 5 OR; 6 XOR; 7 NOT a; 15 NAND
  - 8 SHL a, c=a[3]; 9 SHR a, c=a[0]
  - 10 INC a+1; 11 DEC a-1 (c = carry/borrow)
  - 12 pass a; 13 pass b; 14 const 0
  - c=0 for all other logic, pass and constant ops. Expected zero = (r==0).
- Push: on the clk edge with valid_in=1, the 6-bit {c,zero,r} is written to the FIFO.
- Pop/compare: on the clk edge with valid_out=1 and FIFO non-empty, the head is compared with {carry,zero,alu}.
  - Match: pass_cnt+1.
  - Mismatch: fail_cnt+1 and mismatch=1 for the next cycle.
  - pkt_num+1 in either case.
  - All outputs are registered, 1-cycle latency from the valid_out edge.
- Simultaneous push+pop: both occur; pending unchanged. Allowed when full.
- Push while full, no pop: transaction dropped, err_ovf set.
- valid_out with FIFO empty: err_unf set, no compare, no counter change. This applies even with valid_in in the same cycle, because the DUT has >=1 cycle latency.
- Watchdog: counter clears on pop or when FIFO is empty, otherwise increments. On reaching TIMEOUT it sets err_tmo and holds.
- Counters saturate at all-ones; no wrap.
- FIFO pointers wrap modulo DEPTH; pending distinguishes full from empty.
- States:
  - IDLE: FIFO empty -> ACTIVE on push.
  - ACTIVE -> IDLE when the last entry pops with no push.
  - ACTIVE -> STOP on timeout.
  - STOP is left only by reset; pushes/pops are ignored and halted=1.
- Reset (async, any time, incl. mid-transaction): FIFO flushed, all counters 0, mismatch=0, pending=0, all err_* 0, halted=0, state IDLE.

Optional Feature:
- ALU_CHK_STOP_ON_FAIL_EN
  - Defined: the first mismatch moves the FSM to STOP. Counters and FIFO freeze, halted=1 from the cycle after the mismatch pulse.
  - Undefined: mismatches only count and pulse. halted asserts only on timeout.

Test Plan:
- ADD a=4'h9 b=4'h8 cin=0; DUT returns alu=1 carry=1 zero=0 -> pass_cnt=1, pkt_num=1, mismatch never high.
- SUB a=3 b=3; DUT returns alu=0 carry=0 zero=0 -> mismatch pulse 1 cycle, fail_cnt=1. With ALU_CHK_STOP_ON_FAIL_EN, halted=1 and later pops ignored.
- 8 back-to-back pushes (DEPTH=8) with no valid_out, then a 9th push -> pending=8, err_ovf=1, 8 subsequent correct pops give pass_cnt=8.
- Full FIFO, valid_in and valid_out in the same cycle -> pending stays 8, no err_ovf, pkt_num+1.
- valid_out with empty FIFO -> err_unf=1, counters unchanged. Separately, one push then 64 idle cycles -> err_tmo=1, halted=1.
- Assert reset low with 3 entries pending -> all outputs 0 immediately. After release, a correct SHL a=4'h8 transaction (alu=0 carry=1 zero=1) -> pass_cnt=1.
